vr_hw3_multiword_adder_ctrl: RTL and testbench
==============================================

Name: vr_hw3_multiword_adder_ctrl

Overview:
Sequencer that performs N*M-bit add/subtract by time-multiplexing one M-bit ripple adder (Vr_HW2_ripple_adder_M_bits, instantiated with parameter M), one word per clock.
- Processes words LSB-first and chains the carry through a carry register.
- Start/done handshake to the surrounding datapath; reports carry-out and signed overflow of the full-width result.

Parameters:
M, 8, word width; width of the instantiated ripple adder.
N, 4, number of words per operand (N >= 1); total operand width W = M*N.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RSTN  input  1  asynchronous active-low reset.
START  input  1  request; accepted only when idle (BUSY=0 and DONE=0).
SUB  input  1  operation, sampled with START: 0 = A+B, 1 = A-B.
A  input  W  operand A, sampled with START.
B  input  W  operand B, sampled with START.
BUSY  output  1  high while words are being processed.
DONE  output  1  one-cycle pulse; S/COUT/OVF are final and valid.
S  output  W  result register.
COUT  output  1  carry out of MSB word; for SUB, 1 = no borrow.
OVF  output  1  two's-complement overflow of the W-bit result.

Behaviour:
Reset (RSTN=0, asynchronous, any time including mid-operation):
- state=IDLE, word index=0, carry reg=0, operand regs=0.
- BUSY=0, DONE=0, S=0, COUT=0, OVF=0.
- No DONE is produced for an aborted operation.

States: IDLE, RUN, FIN.

IDLE:
- At the edge with START=1: latch A into AR; latch B into BR, bitwise inverted if SUB=1.
- Load carry reg with SUB; set index=0; go to RUN; BUSY=1 from this edge.
- START=0: stay in IDLE.

RUN, at each edge:
- Adder inputs are AR word[idx], BR word[idx] and the carry reg.
- Write the adder sum into S word[idx]; carry reg <= adder COUT; idx <= idx+1.
- On the edge processing idx=N-1: COUT <= adder COUT; OVF <= (AR msb == BR msb) && (sum msb != AR msb); go to FIN; BUSY=0; DONE=1.
- Other S words are untouched during RUN. S is partially updated while BUSY=1 and is only defined when DONE=1.

FIN:
- DONE high for exactly this one cycle, then IDLE at the next edge. DONE=0 again.
- S/COUT/OVF hold until the next accepted START overwrites them word by word.

Latency and rules:
- START accepted at edge E0. DONE is high in the cycle after edge E0+N.
- Next START can be accepted at edge E0+N+2 (when DONE=1 the block is not idle).
- START during RUN or FIN is ignored; no queuing. A, B and SUB are don't-care outside the accepting edge.
- N=1: a single RUN edge, then FIN.
- Arithmetic is modulo 2^W. The carry chain between words is exact, so the result equals a single W-bit ripple add.
- COUT and OVF are updated only on the last RUN edge; they keep prior values during RUN.

Test Plan:
1. Assert RSTN=0 with random inputs -> BUSY=DONE=COUT=OVF=0, S=0; release and hold START=0 for 10 cycles -> outputs unchanged.
2. M=8, N=4: START, A=0x000000FF, B=0x00000001, SUB=0 -> BUSY high 4 cycles; DONE in the cycle after edge E0+4; S=0x00000100, COUT=0, OVF=0.
3. A=0xFFFFFFFF, B=0x00000001, add -> S=0x00000000, COUT=1, OVF=0. Then A=0x7FFFFFFF, B=0x00000001, add -> S=0x80000000, COUT=0, OVF=1.
4. SUB, A=0x00000005, B=0x00000007 -> S=0xFFFFFFFE, COUT=0, OVF=0. Then SUB, A=0x80000000, B=0x00000001 -> S=0x7FFFFFFF, COUT=1, OVF=1.
5. START held high continuously with changing A/B -> operations only start at edges where the block is idle, one every N+2 cycles; each result matches the operands sampled at its accepting edge.
6. Pulse RSTN low during the 2nd RUN cycle -> immediate zero outputs, no DONE. Then A=0x12345678, B=0x11111111, add -> S=0x23456789, COUT=0, OVF=0.

Source files
------------

// File: rtl/vr_hw3_multiword_adder_ctrl.sv
// Multi-word add/subtract sequencer: one shared M-bit ripple adder walks the
// operands LSB word first, chaining the carry between words through a register.

module Vr_HW2_ripple_adder_M_bits #(
  parameter int M = 8
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic         cin_i,
  output logic [M-1:0] sum_o,
  output logic         cout_o
);

  logic carry;

  // Plain ripple chain; the carry is a loop-local walk so no combinational self-loop is seen.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < M; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

module vr_hw3_multiword_adder_ctrl #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             SUB,
  input  logic [M*N-1:0]   A,
  input  logic [M*N-1:0]   B,
  output logic             BUSY,
  output logic             DONE,
  output logic [M*N-1:0]   S,
  output logic             COUT,
  output logic             OVF
);

  localparam int W  = M * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic           carry_q;
  logic [W-1:0]   ar_q;
  logic [W-1:0]   br_q;
  logic [W-1:0]   s_q;
  logic           cout_q;
  logic           ovf_q;
  logic           busy_q;
  logic           done_q;

  logic [M-1:0]   aWord_d;
  logic [M-1:0]   bWord_d;
  logic [M-1:0]   sum_d;
  logic           addCout_d;
  logic           lastWord_d;

  // Word select for the shared adder; B was already inverted at START for subtraction.
  always_comb begin
    aWord_d = '0;
    bWord_d = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        aWord_d = ar_q[k*M +: M];
        bWord_d = br_q[k*M +: M];
      end
    end
    lastWord_d = (idx_q == IW'(N - 1));
  end

  Vr_HW2_ripple_adder_M_bits #(.M(M)) u_adder (
    .a_i    (aWord_d),
    .b_i    (bWord_d),
    .cin_i  (carry_q),
    .sum_o  (sum_d),
    .cout_o (addCout_d)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ar_q    <= '0;
      br_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            ar_q    <= A;
            br_q    <= SUB ? ~B : B;
            carry_q <= SUB;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) s_q[k*M +: M] <= sum_d;
          end
          carry_q <= addCout_d;
          idx_q   <= idx_q + IW'(1);
          // Flags reflect the full-width result, so they only move on the top word.
          if (lastWord_d) begin
            cout_q  <= addCout_d;
            ovf_q   <= (ar_q[W-1] == br_q[W-1]) && (sum_d[M-1] != ar_q[W-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_vr_hw3_multiword_adder_ctrl.sv
// Self-checking bench for vr_hw3_multiword_adder_ctrl: directed and random
// operations compared against a signed/unsigned arithmetic reference model.

module tb_vr_hw3_multiword_adder_ctrl;

  localparam int M = 8;
  localparam int N = 4;
  localparam int W = M * N;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         START;
  logic         SUB;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] S;
  logic         COUT;
  logic         OVF;

  int   nVectors     = 0;
  int   nMiscompares = 0;
  logic prevCout     = 1'b0;
  logic prevOvf      = 1'b0;

  logic [W+1:0] expTrip;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rs;

  always #5 CLK = ~CLK;

  vr_hw3_multiword_adder_ctrl #(.M(M), .N(N)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .COUT  (COUT),
    .OVF   (OVF)
  );

  // Reference: result from plain modular arithmetic, carry as "no unsigned
  // overflow/borrow", overflow from exact signed arithmetic out of range.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    longint sa, sb, sr, maxS, minS;
    logic [W-1:0] res;
    logic c, o;
    sa   = $signed(a);
    sb   = $signed(b);
    maxS = (longint'(1) <<< (W - 1)) - 1;
    minS = -(longint'(1) <<< (W - 1));
    if (sub) begin
      res = a - b;
      c   = (a >= b);
      sr  = sa - sb;
    end else begin
      res = a + b;
      c   = ((longint'(a) + longint'(b)) >= (longint'(1) <<< W));
      sr  = sa + sb;
    end
    o = (sr > maxS) || (sr < minS);
    return {o, c, res};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents an operation at a falling edge, lets one rising edge accept it,
  // then scribbles junk on the operands to show they are don't-care afterwards.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    START = 1'b1;
    A     = a;
    B     = b;
    SUB   = sub;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    A     = $urandom;
    B     = $urandom;
    SUB   = 1'($urandom_range(0, 1));
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] expS, input logic expC,
                       input logic expO);
    applyStimulus(a, b, sub);
    for (int k = 0; k < N; k++) begin
      checkOutput({tag, ".busy"}, 64'(BUSY), 64'd1);
      checkOutput({tag, ".doneEarly"}, 64'(DONE), 64'd0);
      checkOutput({tag, ".coutHold"}, 64'(COUT), 64'(prevCout));
      checkOutput({tag, ".ovfHold"}, 64'(OVF), 64'(prevOvf));
      @(negedge CLK);
    end
    checkOutput({tag, ".busyEnd"}, 64'(BUSY), 64'd0);
    checkOutput({tag, ".done"}, 64'(DONE), 64'd1);
    checkOutput({tag, ".s"}, 64'(S), 64'(expS));
    checkOutput({tag, ".cout"}, 64'(COUT), 64'(expC));
    checkOutput({tag, ".ovf"}, 64'(OVF), 64'(expO));
    prevCout = expC;
    prevOvf  = expO;
    @(negedge CLK);
    checkOutput({tag, ".donePulse"}, 64'(DONE), 64'd0);
    checkOutput({tag, ".sHold"}, 64'(S), 64'(expS));
  endtask

  task automatic runRandomOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub);
    logic [W+1:0] r;
    r = refModel(a, b, sub);
    runOp(tag, a, b, sub, r[W-1:0], r[W], r[W+1]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset asserted with random inputs toggling.
    RSTN  = 1'b0;
    START = 1'($urandom_range(0, 1));
    SUB   = 1'($urandom_range(0, 1));
    A     = $urandom;
    B     = $urandom;
    repeat (3) @(negedge CLK);
    checkOutput("rst.busy", 64'(BUSY), 64'd0);
    checkOutput("rst.done", 64'(DONE), 64'd0);
    checkOutput("rst.s", 64'(S), 64'd0);
    checkOutput("rst.cout", 64'(COUT), 64'd0);
    checkOutput("rst.ovf", 64'(OVF), 64'd0);
    RSTN  = 1'b1;
    START = 1'b0;
    for (int k = 0; k < 10; k++) begin
      A = $urandom;
      B = $urandom;
      @(negedge CLK);
      checkOutput("idle.busy", 64'(BUSY), 64'd0);
      checkOutput("idle.done", 64'(DONE), 64'd0);
      checkOutput("idle.s", 64'(S), 64'd0);
      checkOutput("idle.flags", 64'({COUT, OVF}), 64'd0);
    end

    // Directed carry, overflow and borrow corners.
    runOp("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    runOp("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    runOp("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    runOp("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    runOp("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Random operations against the reference model.
    for (int k = 0; k < 16; k++) begin
      runRandomOp("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // START held high: only edges that find the block idle accept, one per N+2 edges.
    for (int c = 0; c < 3 * (N + 2); c++) begin
      ra    = $urandom;
      rb    = $urandom;
      rs    = 1'($urandom_range(0, 1));
      START = 1'b1;
      A     = ra;
      B     = rb;
      SUB   = rs;
      if (c % (N + 2) == 0) expTrip = refModel(ra, rb, rs);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("held.busy", 64'(BUSY), 64'((c % (N + 2)) < N));
      if (c % (N + 2) == N) begin
        checkOutput("held.done", 64'(DONE), 64'd1);
        checkOutput("held.s", 64'(S), 64'(expTrip[W-1:0]));
        checkOutput("held.cout", 64'(COUT), 64'(expTrip[W]));
        checkOutput("held.ovf", 64'(OVF), 64'(expTrip[W+1]));
        prevCout = expTrip[W];
        prevOvf  = expTrip[W+1];
      end else begin
        checkOutput("held.noDone", 64'(DONE), 64'd0);
      end
    end
    START = 1'b0;

    // Abort during the second RUN cycle.
    applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0);
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    checkOutput("abort.busy", 64'(BUSY), 64'd0);
    checkOutput("abort.done", 64'(DONE), 64'd0);
    checkOutput("abort.s", 64'(S), 64'd0);
    checkOutput("abort.flags", 64'({COUT, OVF}), 64'd0);
    @(negedge CLK);
    RSTN     = 1'b1;
    prevCout = 1'b0;
    prevOvf  = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(negedge CLK);
      checkOutput("abort.noDone", 64'(DONE), 64'd0);
      checkOutput("abort.noBusy", 64'(BUSY), 64'd0);
    end
    runOp("post_abort", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
